// File: rtl/noc_flit_axis_receiver_if.sv
// AXI-Stream beat channel driven by the NoC flit receiver.
interface noc_flit_axis_receiver_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 2
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/noc_flit_axis_receiver.sv
// NoC ejection endpoint: credit-flow flit FIFO, then SERIALIZATION_FACTOR
// flits are packed LSB-first into one registered AXI-Stream beat.
module noc_flit_axis_receiver #(
    parameter int TDATA_WIDTH          = 64,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 2,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int FLIT_BUFFER_DEPTH    = 2
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic                  overflow_err,
    noc_flit_axis_receiver_if.master axis_out
);
    localparam int SF   = SERIALIZATION_FACTOR;
    localparam int FW   = FLIT_WIDTH;
    localparam int D    = FLIT_BUFFER_DEPTH;
    localparam int PW   = (D > 1) ? $clog2(D) : 1;
    localparam int NW   = $clog2(D + 1);
    localparam int CW   = (SF > 1) ? $clog2(SF) : 1;

    typedef struct packed {
        logic [FW-1:0]         data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;

    flit_t                  r_mem [D];
    logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [NW-1:0]          r_count;
    logic                   r_ovf;
    logic [CW-1:0]          r_cnt;
    logic [FW-1:0]          r_slots [SF];
    logic [DEST_WIDTH-1:0]  r_dest0;
    logic                   r_tvalid, r_tlast, r_credit;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic [TID_WIDTH-1:0]   r_tid;
    logic [TDEST_WIDTH-1:0] r_tdest;

    flit_t                  w_head;
    logic                   w_empty, w_full, w_final, w_out_free, w_pop, w_push;
    logic [TDATA_WIDTH-1:0] w_beat;
    logic [DEST_WIDTH-1:0]  w_beat_dest;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_head      = r_mem[r_rd_ptr];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == NW'(D));
    assign w_final     = (r_cnt == CW'(SF - 1)) || w_head.tail;
    assign w_out_free  = !r_tvalid || axis_out.tready;
    // Non-final flits never need the output register, so only the final one stalls.
    assign w_pop       = !w_empty && (!w_final || w_out_free);
    assign w_push      = send_in && !w_full;
    assign w_beat_dest = (r_cnt == '0) ? w_head.dest : r_dest0;

    always_comb begin
        w_beat = '0;
        for (int k = 0; k < SF; k++) begin
            if (k < int'(r_cnt))
                w_beat[k*FW +: FW] = r_slots[k];
            else if (k == int'(r_cnt))
                w_beat[k*FW +: FW] = w_head.data;
        end
    end

    // Pop frees space only after the edge, so a write into a full FIFO is dropped.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{data: data_in, dest: dest_in, tail: is_tail_in};
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= f_next(r_rd_ptr);
            r_count <= r_count + NW'(w_push) - NW'(w_pop);
            if (send_in && w_full)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_cnt   <= '0;
            r_slots <= '{default: '0};
            r_dest0 <= '0;
        end else if (w_pop) begin
            if (w_final) begin
                r_cnt <= '0;
            end else begin
                r_slots[r_cnt] <= w_head.data;
                if (r_cnt == '0)
                    r_dest0 <= w_head.dest;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tid    <= '0;
            r_tdest  <= '0;
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_pop && w_final) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_beat;
                r_tlast  <= w_head.tail;
                r_tid    <= w_beat_dest[DEST_WIDTH-1 -: TID_WIDTH];
                r_tdest  <= w_beat_dest[TDEST_WIDTH-1:0];
            end else if (axis_out.tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign axis_out.tvalid = r_tvalid;
    assign axis_out.tdata  = r_tdata;
    assign axis_out.tlast  = r_tlast;
    assign axis_out.tid    = r_tid;
    assign axis_out.tdest  = r_tdest;
    assign credit_out      = r_credit;
    assign overflow_err    = r_ovf;
endmodule

// File: tb/tb_noc_flit_axis_receiver.sv
// Directed cycle-table bench for the flit receiver (SF=2) plus SF=4 early-tail sequence.
module tb_noc_flit_axis_receiver;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] data2;
    logic [3:0]  dest2;
    logic        tail2, send2, cr2, ovf2;
    logic [15:0] data4;
    logic [3:0]  dest4;
    logic        tail4, send4, cr4, ovf4;

    noc_flit_axis_receiver_if #(.TDATA_WIDTH(64), .TID_WIDTH(2), .TDEST_WIDTH(2)) axis2 ();
    noc_flit_axis_receiver_if #(.TDATA_WIDTH(64), .TID_WIDTH(2), .TDEST_WIDTH(2)) axis4 ();

    noc_flit_axis_receiver #(.TDATA_WIDTH(64), .SERIALIZATION_FACTOR(2)) dut2 (
        .clk_noc(clk), .rst_noc_sync(rst), .data_in(data2), .dest_in(dest2),
        .is_tail_in(tail2), .send_in(send2), .credit_out(cr2), .overflow_err(ovf2),
        .axis_out(axis2.master));

    noc_flit_axis_receiver #(.TDATA_WIDTH(64), .SERIALIZATION_FACTOR(4)) dut4 (
        .clk_noc(clk), .rst_noc_sync(rst), .data_in(data4), .dest_in(dest4),
        .is_tail_in(tail4), .send_in(send4), .credit_out(cr4), .overflow_err(ovf4),
        .axis_out(axis4.master));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, send;
        logic [31:0] data;
        logic [3:0]  dest;
        logic        tail, rdy;
        logic        evld;
        logic [63:0] edata;
        logic        elast;
        logic [3:0]  eid;
        logic        ecr, eovf, dchk;
    } vec_t;

    function automatic vec_t mk(input logic r, s, input logic [31:0] d, input logic [3:0] de,
                                input logic t, rd, ev, input logic [63:0] ed, input logic el,
                                input logic [3:0] ei, input logic ec, eo, dc);
        vec_t v;
        v.rst = r; v.send = s; v.data = d; v.dest = de; v.tail = t; v.rdy = rd;
        v.evld = ev; v.edata = ed; v.elast = el; v.eid = ei; v.ecr = ec; v.eovf = eo; v.dchk = dc;
        return v;
    endfunction

    vec_t vq[$];

    logic [15:0] f4d [6] = '{16'h1234, 16'h5678, 16'hAAA1, 16'hAAA2, 16'hAAA3, 16'hAAA4};
    logic [3:0]  f4e [6] = '{4'h9, 4'h0, 4'h2, 4'h7, 4'h7, 4'h7};
    logic        f4t [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int ncr, nbeat, gaps;
        logic [31:0] lo, hi;
        logic [63:0] bd[$];
        logic [3:0]  bi[$];
        logic        bl[$];

        rst = 1'b1; send2 = 1'b0; data2 = '0; dest2 = '0; tail2 = 1'b0;
        send4 = 1'b0; data4 = '0; dest4 = '0; tail4 = 1'b0;
        axis2.tready = 1'b1; axis4.tready = 1'b1;

        //           rst send data           dest  tail rdy | vld data                    last id   cr ovf dchk
        vq.push_back(mk(H, L, 32'h0,        4'h0, L, H,  L, 64'h0,                   L, 4'h0, L, L, H));
        // basic SF=2 beat
        vq.push_back(mk(L, H, 32'h11111111, 4'h6, L, H,  L, 64'h0,                   L, 4'h0, L, L, L));
        vq.push_back(mk(L, H, 32'h22222222, 4'h6, H, H,  L, 64'h0,                   L, 4'h0, H, L, L));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  H, 64'h22222222_11111111,   H, 4'h6, H, L, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  L, 64'h0,                   L, 4'h0, L, L, L));
        // backpressure: first beat held, second beat loads on drain without a bubble
        vq.push_back(mk(L, H, 32'hA0000001, 4'h9, L, L,  L, 64'h0,                   L, 4'h0, L, L, L));
        vq.push_back(mk(L, H, 32'hA0000002, 4'h9, H, L,  L, 64'h0,                   L, 4'h0, H, L, L));
        vq.push_back(mk(L, H, 32'hB0000003, 4'h3, L, L,  H, 64'hA0000002_A0000001,   H, 4'h9, H, L, H));
        vq.push_back(mk(L, H, 32'hB0000004, 4'h3, H, L,  H, 64'hA0000002_A0000001,   H, 4'h9, H, L, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, L,  H, 64'hA0000002_A0000001,   H, 4'h9, L, L, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, L,  H, 64'hA0000002_A0000001,   H, 4'h9, L, L, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  H, 64'hB0000004_B0000003,   H, 4'h3, H, L, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  L, 64'h0,                   L, 4'h0, L, L, L));
        // overflow: single-flit beats stall behind a held output
        vq.push_back(mk(L, H, 32'hC1,       4'h0, H, L,  L, 64'h0,                   L, 4'h0, L, L, L));
        vq.push_back(mk(L, H, 32'hC2,       4'h0, H, L,  H, 64'hC1,                  H, 4'h0, H, L, H));
        vq.push_back(mk(L, H, 32'hC3,       4'h0, H, L,  H, 64'hC1,                  H, 4'h0, L, L, H));
        vq.push_back(mk(L, H, 32'hC4,       4'h0, H, L,  H, 64'hC1,                  H, 4'h0, L, H, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, L,  H, 64'hC1,                  H, 4'h0, L, H, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  H, 64'hC2,                  H, 4'h0, H, H, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  H, 64'hC3,                  H, 4'h0, H, H, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  L, 64'h0,                   L, 4'h0, L, H, L));
        // reset mid-beat discards the partial slot
        vq.push_back(mk(L, H, 32'hDEAD0001, 4'hF, L, H,  L, 64'h0,                   L, 4'h0, L, H, L));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  L, 64'h0,                   L, 4'h0, H, H, L));
        vq.push_back(mk(H, L, 32'h0,        4'h0, L, H,  L, 64'h0,                   L, 4'h0, L, L, H));
        vq.push_back(mk(L, H, 32'h5555,     4'h4, L, H,  L, 64'h0,                   L, 4'h0, L, L, L));
        vq.push_back(mk(L, H, 32'hAAAA,     4'h4, H, H,  L, 64'h0,                   L, 4'h0, H, L, L));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  H, 64'h0000AAAA_00005555,   H, 4'h4, H, L, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  L, 64'h0,                   L, 4'h0, L, L, L));
        // full beat without tail; second flit's dest is ignored
        vq.push_back(mk(L, H, 32'h33,       4'hA, L, H,  L, 64'h0,                   L, 4'h0, L, L, L));
        vq.push_back(mk(L, H, 32'h44,       4'h5, L, H,  L, 64'h0,                   L, 4'h0, H, L, L));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  H, 64'h00000044_00000033,   L, 4'hA, H, L, H));
        vq.push_back(mk(L, L, 32'h0,        4'h0, L, H,  L, 64'h0,                   L, 4'h0, L, L, L));

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; send2 = vq[i].send; data2 = vq[i].data;
            dest2 = vq[i].dest; tail2 = vq[i].tail; axis2.tready = vq[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d tvalid", i), 64'(axis2.tvalid), 64'(vq[i].evld));
            chk($sformatf("v%0d credit", i), 64'(cr2), 64'(vq[i].ecr));
            chk($sformatf("v%0d overflow", i), 64'(ovf2), 64'(vq[i].eovf));
            if (vq[i].dchk) begin
                chk($sformatf("v%0d tdata", i), axis2.tdata, vq[i].edata);
                chk($sformatf("v%0d tlast", i), 64'(axis2.tlast), 64'(vq[i].elast));
                chk($sformatf("v%0d tid_tdest", i), 64'({axis2.tid, axis2.tdest}), 64'(vq[i].eid));
            end
        end

        // streaming: 64 back-to-back flits, tready=1
        ncr = 0; nbeat = 0; gaps = 0;
        axis2.tready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (c < 64) begin
                send2 = 1'b1; data2 = 32'h1000 + 32'(c); dest2 = c[3:0]; tail2 = c[0];
            end else begin
                send2 = 1'b0;
            end
            @(posedge clk); #1;
            if (cr2) ncr++;
            else if (c >= 1 && c <= 64) gaps++;
            if (axis2.tvalid) begin
                lo = 32'h1000 + 32'(2 * nbeat);
                hi = lo + 32'd1;
                chk($sformatf("stream beat%0d tdata", nbeat), axis2.tdata, {hi, lo});
                chk($sformatf("stream beat%0d id", nbeat), 64'({axis2.tid, axis2.tdest}), 64'(lo[3:0]));
                chk($sformatf("stream beat%0d tlast", nbeat), 64'(axis2.tlast), 64'd1);
                nbeat++;
            end
        end
        chk("stream credits", 64'(ncr), 64'd64);
        chk("stream beats", 64'(nbeat), 64'd32);
        chk("stream credit gaps", 64'(gaps), 64'd0);

        // SF=4: early-tail beat then a full beat
        ncr = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 6) begin
                send4 = 1'b1; data4 = f4d[c]; dest4 = f4e[c]; tail4 = f4t[c];
            end else begin
                send4 = 1'b0;
            end
            @(posedge clk); #1;
            if (cr4) ncr++;
            if (axis4.tvalid) begin
                bd.push_back(axis4.tdata);
                bi.push_back({axis4.tid, axis4.tdest});
                bl.push_back(axis4.tlast);
            end
        end
        chk("sf4 credits", 64'(ncr), 64'd6);
        chk("sf4 beats", 64'(bd.size()), 64'd2);
        if (bd.size() >= 2) begin
            chk("sf4 early tdata", bd[0], 64'h0000_0000_5678_1234);
            chk("sf4 early id", 64'(bi[0]), 64'h9);
            chk("sf4 early tlast", 64'(bl[0]), 64'd1);
            chk("sf4 full tdata", bd[1], 64'hAAA4_AAA3_AAA2_AAA1);
            chk("sf4 full id", 64'(bi[1]), 64'h2);
            chk("sf4 full tlast", 64'(bl[1]), 64'd1);
        end
        chk("sf4 overflow", 64'(ovf4), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
